// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath.
// Refractory counters are built only when LIF_REFRACTORY_EN is defined.
module lif_neuron_array #(
  parameter int unsigned N          = 4,
  parameter int unsigned IDXW       = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned VW         = 16,
  parameter int unsigned IW         = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned V_TH       = 100,
  parameter int unsigned V_RESET    = 0,
  parameter int unsigned REFRAC     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDXW-1:0]      in_idx,
  input  logic signed [IW-1:0] in_cur,
  output logic                 busy,
  output logic [N-1:0]         spikes,
  output logic                 spikes_valid,
  output logic                 tick_overrun
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = VW + 1;
  localparam int unsigned SW = VW + 2;
  localparam int unsigned RW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  localparam logic signed [SW-1:0] ACC_MAX = SW'({1'b0, {VW{1'b1}}});
  localparam logic signed [SW-1:0] ACC_MIN = {2'b11, {VW{1'b0}}};
  localparam logic signed [SW-1:0] V_MAX   = SW'({1'b0, {VW{1'b1}}});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [VW-1:0]        r_v   [N];
  logic signed [AW-1:0] r_acc [N];
  logic [KW-1:0]        r_k;
  logic [N-1:0]         r_spikes;

  logic                 w_start;
  logic                 w_step;
  logic                 w_accept;
  logic [VW-1:0]        w_v_cur;
  logic signed [AW-1:0] w_acc_cur;
  logic signed [AW-1:0] w_acc_tgt;
  logic signed [SW-1:0] w_acc_sum;
  logic signed [AW-1:0] w_acc_new;
  logic [VW-1:0]        w_leak;
  logic signed [SW-1:0] w_v_sum;
  logic [VW-1:0]        w_v_next;
  logic                 w_fire;
  logic [RW-1:0]        w_ref_cur;
  logic                 w_in_ref;

`ifdef LIF_REFRACTORY_EN
  logic [RW-1:0] r_ref [N];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and sweep control
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_accept     = 1'b0;
    tick_overrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = in_valid;
        if (tick) begin
          w_start     = 1'b1;
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_step       = 1'b1;
        tick_overrun = tick;
        if (32'(r_k) == N - 1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        tick_overrun = tick;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign spikes_valid = (r_state == S_DONE);
  assign spikes       = r_spikes;

  // Select the neuron under update and the accumulator targeted by the input event
  always_comb begin
    w_v_cur   = '0;
    w_acc_cur = '0;
    w_acc_tgt = '0;
    w_ref_cur = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (32'(r_k) == j) begin
        w_v_cur   = r_v[j];
        w_acc_cur = r_acc[j];
`ifdef LIF_REFRACTORY_EN
        w_ref_cur = r_ref[j];
`endif
      end
      if (32'(in_idx) == j) begin
        w_acc_tgt = r_acc[j];
      end
    end
  end

  // Saturating accumulate of the incoming current
  always_comb begin
    w_acc_sum = SW'(w_acc_tgt) + SW'(in_cur);
    if (w_acc_sum > ACC_MAX) begin
      w_acc_new = AW'(ACC_MAX);
    end else if (w_acc_sum < ACC_MIN) begin
      w_acc_new = AW'(ACC_MIN);
    end else begin
      w_acc_new = AW'(w_acc_sum);
    end
  end

  // Shared leak/integrate datapath, clamped to the unsigned membrane range
  always_comb begin
    w_leak  = w_v_cur >> LEAK_SHIFT;
    w_v_sum = $signed(SW'(w_v_cur)) - $signed(SW'(w_leak)) + SW'(w_acc_cur);
    if (w_v_sum < $signed(SW'(0))) begin
      w_v_next = '0;
    end else if (w_v_sum > V_MAX) begin
      w_v_next = '1;
    end else begin
      w_v_next = VW'(w_v_sum);
    end
    w_fire   = (32'(w_v_next) >= V_TH);
    w_in_ref = (w_ref_cur != '0);
  end

  // Per-neuron state: event writes only in IDLE, sweep writes only in SWEEP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k      <= '0;
      r_spikes <= '0;
      for (int unsigned j = 0; j < N; j++) begin
        r_v[j]   <= '0;
        r_acc[j] <= '0;
`ifdef LIF_REFRACTORY_EN
        r_ref[j] <= '0;
`endif
      end
    end else begin
      if (w_start) begin
        r_k      <= '0;
        r_spikes <= '0;
      end else if (w_step) begin
        r_k <= r_k + KW'(1);
      end
      for (int unsigned j = 0; j < N; j++) begin
        if (w_accept && (32'(in_idx) == j)) begin
          r_acc[j] <= w_acc_new;
        end
        if (w_step && (32'(r_k) == j)) begin
          r_acc[j] <= '0;
          if (w_in_ref) begin
            r_v[j] <= VW'(V_RESET);
`ifdef LIF_REFRACTORY_EN
            r_ref[j] <= w_ref_cur - RW'(1);
`endif
          end else if (w_fire) begin
            r_v[j]      <= VW'(V_RESET);
            r_spikes[j] <= 1'b1;
`ifdef LIF_REFRACTORY_EN
            r_ref[j] <= RW'(REFRAC);
`endif
          end else begin
            r_v[j] <= w_v_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios plus randomized sweeps
// compared against a plain-integer neuron model.
module tb_lif_neuron_array;

  localparam int N          = 4;
  localparam int IDXW       = 3;
  localparam int VW         = 16;
  localparam int IW         = 8;
  localparam int LEAK_SHIFT = 3;
  localparam int V_TH       = 100;
  localparam int V_RESET    = 0;
  localparam int REFRAC     = 2;
  localparam int VMAX       = (1 << VW) - 1;
  localparam int AMIN       = -(1 << VW);
`ifdef LIF_REFRACTORY_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tick;
  logic                 in_valid;
  logic                 in_ready;
  logic [IDXW-1:0]      in_idx;
  logic signed [IW-1:0] in_cur;
  logic                 busy;
  logic [N-1:0]         spikes;
  logic                 spikes_valid;
  logic                 tick_overrun;

  lif_neuron_array #(
    .N(N), .IDXW(IDXW), .VW(VW), .IW(IW), .LEAK_SHIFT(LEAK_SHIFT),
    .V_TH(V_TH), .V_RESET(V_RESET), .REFRAC(REFRAC)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(in_valid),
    .in_ready(in_ready), .in_idx(in_idx), .in_cur(in_cur), .busy(busy),
    .spikes(spikes), .spikes_valid(spikes_valid), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int mv   [N];
  int macc [N];
  int mref [N];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; macc[i] = 0; mref[i] = 0;
    end
  endtask

  task automatic model_event(input int idx, input int cur);
    if (idx < N) macc[idx] = clamp(macc[idx] + cur, AMIN, VMAX);
  endtask

  task automatic model_sweep(output logic [N-1:0] sp);
    int vn;
    sp = '0;
    for (int k = 0; k < N; k++) begin
      if (REF_EN && mref[k] > 0) begin
        mv[k] = V_RESET;
        mref[k]--;
      end else begin
        vn = clamp(mv[k] - (mv[k] / (1 << LEAK_SHIFT)) + macc[k], 0, VMAX);
        if (vn >= V_TH) begin
          sp[k]   = 1'b1;
          mv[k]   = V_RESET;
          mref[k] = REFRAC;
        end else begin
          mv[k] = vn;
        end
      end
      macc[k] = 0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_event(input int idx, input int cur);
    in_valid = 1'b1;
    in_idx   = IDXW'(idx);
    in_cur   = IW'(cur);
    #1;
    chk1("ready_idle", in_ready, 1'b1);
    model_event(idx, cur);
    next_cycle();
    in_valid = 1'b0;
  endtask

  // Full sweep with timing checks; optional same-cycle event, overrun tick and blocked event
  task automatic do_sweep(input bit same_ev, input int ev_idx, input int ev_cur,
                          input bit ovr, input bit busy_ev);
    logic [N-1:0] exp_sp;
    tick = 1'b1;
    if (same_ev) begin
      in_valid = 1'b1;
      in_idx   = IDXW'(ev_idx);
      in_cur   = IW'(ev_cur);
      model_event(ev_idx, ev_cur);
    end
    #1;
    chk1("ready_at_tick", in_ready, 1'b1);
    chk1("no_overrun_idle", tick_overrun, 1'b0);
    model_sweep(exp_sp);
    next_cycle();
    tick     = 1'b0;
    in_valid = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      chk1("busy_sweep", busy, 1'b1);
      chk1("ready_low_sweep", in_ready, 1'b0);
      chk1("valid_timing", spikes_valid, (c == N + 1));
      if (c == N + 1) chkv("spikes", spikes, exp_sp);
      if (ovr && c == 2) begin
        tick = 1'b1;
        #1;
        chk1("overrun_pulse", tick_overrun, 1'b1);
      end
      if (busy_ev && c == 1) begin
        in_valid = 1'b1;
        in_idx   = IDXW'($urandom_range(0, N - 1));
        in_cur   = IW'(127);
      end
      next_cycle();
      tick     = 1'b0;
      in_valid = 1'b0;
    end
    chk1("busy_end", busy, 1'b0);
    chk1("ready_end", in_ready, 1'b1);
    chk1("valid_end", spikes_valid, 1'b0);
    chkv("spikes_hold", spikes, exp_sp);
    if (ovr) begin
      next_cycle();
      chk1("no_extra_sweep", busy, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] dummy;
    int nev;
    reset    = 1'b1;
    tick     = 1'b0;
    in_valid = 1'b0;
    in_idx   = '0;
    in_cur   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk1("rst_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", spikes_valid, 1'b0);
    chkv("rst_spikes", spikes, '0);
    chk1("rst_overrun", tick_overrun, 1'b0);

    // Single-neuron integration: 50, 94, then spike at 133
    for (int i = 0; i < 3; i++) begin
      send_event(1, 50);
      do_sweep(1'b0, 0, 0, 1'b0, 1'b0);
    end
    chkv("integrate_spike", spikes, 4'b0010);

    // Negative current clamps membrane at zero
    send_event(2, -128);
    do_sweep(1'b0, 0, 0, 1'b0, 1'b0);
    chkv("neg_sat", spikes, 4'b0000);

    // Spike followed by ticks carrying +127 exercises refractory behaviour
    send_event(3, 127);
    do_sweep(1'b0, 0, 0, 1'b0, 1'b0);
    chkv("ref_first_spike", spikes, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      send_event(3, 127);
      do_sweep(1'b0, 0, 0, 1'b0, 1'b0);
    end

    // Accumulator saturation, then confirm acc was cleared
    for (int i = 0; i < 600; i++) send_event(0, 127);
    do_sweep(1'b0, 0, 0, 1'b0, 1'b0);
    chkv("acc_sat_spike", spikes, 4'b0001);
    do_sweep(1'b0, 0, 0, 1'b0, 1'b0);

    // Out-of-range index dropped; overrun; blocked event while busy; same-cycle event
    send_event(5, 127);
    send_event(7, 127);
    do_sweep(1'b0, 0, 0, 1'b1, 1'b1);
    do_sweep(1'b1, 2, 127, 1'b0, 1'b0);
    chkv("same_cycle_event", spikes, 4'b0100);

    // Reset in the middle of a sweep
    for (int i = 0; i < N; i++) send_event(i, 120);
    tick = 1'b1;
    next_cycle();
    tick = 1'b0;
    chk1("abort_busy", busy, 1'b1);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk1("abort_ready", in_ready, 1'b1);
    chk1("abort_busy_low", busy, 1'b0);
    chkv("abort_spikes", spikes, '0);
    model_reset();
    for (int c = 0; c < N + 2; c++) begin
      chk1("abort_no_valid", spikes_valid, 1'b0);
      next_cycle();
    end
    do_sweep(1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized sweeps
    for (int s = 0; s < 40; s++) begin
      nev = int'($urandom_range(0, 6));
      for (int e = 0; e < nev; e++)
        send_event(int'($urandom_range(0, 7)), int'($urandom_range(0, 227)) - 100);
      do_sweep(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 227)) - 100,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    model_sweep(dummy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
